// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier that borrows an external alu32.
// Define ALU_MUL_EARLY_EXIT_EN to stop once the remaining multiplier is zero.
module alu_mul_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_gin,
   input  logic [31:0] alu_sum,
   input  logic [1:0]  alu_stat,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ADD,
      SHIFT,
      DONE
   } state_t;

   state_t      state, state_n;
   logic [31:0] acc, mcand, mplier, prod_q;
   logic [4:0]  cnt;
   logic        last;
   logic        unused_stat;

   assign unused_stat = alu_stat[0];

`ifdef ALU_MUL_EARLY_EXIT_EN
   assign last = (mplier[31:1] == 31'd0) || (cnt == 5'd31);
`else
   assign last = (cnt == 5'd31);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         prod_q <= '0;
      end else begin
         state <= state_n;
         unique case (state)
            IDLE: begin
               if (start) begin
                  acc    <= '0;
                  mcand  <= op_a;
                  mplier <= op_b;
                  cnt    <= '0;
               end
            end
            ADD: acc <= alu_sum;
            SHIFT: begin
               mcand  <= alu_sum;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
            end
            DONE: prod_q <= acc;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      alu_gin = 3'b010;
      alu_a   = '0;
      alu_b   = '0;
      unique case (state)
         IDLE: begin
            if (start) state_n = CHECK;
         end
         CHECK: begin
            alu_gin = 3'b000;
            alu_a   = mplier;
            alu_b   = 32'd1;
            state_n = alu_stat[1] ? SHIFT : ADD;
         end
         ADD: begin
            alu_a   = acc;
            alu_b   = mcand;
            state_n = SHIFT;
         end
         SHIFT: begin
            alu_gin = 3'b100;
            alu_a   = mcand;
            alu_b   = 32'd1;
            state_n = last ? DONE : CHECK;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // The result is visible during the done pulse and held afterwards.
   assign busy    = (state == CHECK) || (state == ADD) || (state == SHIFT);
   assign done    = (state == DONE);
   assign product = done ? acc : prod_q;

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have port op_a  input  32  multiplicand; sampled with start.
REQ-005 SHALL have port op_b  input  32  multiplier; sampled with start.
REQ-006 SHALL have port alu_a  output  32  operand a driven to external alu32.
REQ-007 SHALL have port alu_b  output  32  operand b driven to external alu32.
REQ-008 SHALL have port alu_gin  output  3  ALU control line driven to external alu32.
REQ-009 SHALL have port alu_sum  input  32  combinational result returned by alu32.
REQ-010 SHALL have port alu_stat  input  2  alu32 status; bit1 = result zero, bit0 = result sign clear.
REQ-011 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port product  output  32  low 32 bits of op_a*op_b; held until the next accepted start.

Function
REQ-014 SHALL use states IDLE, CHECK, ADD, SHIFT, DONE, with internal registers acc, mcand, mplier (32 bits each) and a 5-bit iteration counter.
REQ-015 SHALL, in IDLE with start=1, load acc=0, mcand=op_a, mplier=op_b, counter=0, and go to CHECK.
REQ-016 SHALL, in CHECK, drive gin=000 (AND), a=mplier, b=1; go to ADD if alu_stat[1]=0, else go to SHIFT.
REQ-017 SHALL, in ADD, drive gin=010, a=acc, b=mcand; register acc<=alu_sum; go to SHIFT.
REQ-018 SHALL, in SHIFT, drive gin=100 (SLLV), a=mcand, b=1; register mcand<=alu_sum, mplier<=mplier>>1, counter<=counter+1.
REQ-019 SHALL, leaving SHIFT, go to DONE when the termination rule (REQ-029/030) holds, else go to CHECK.
REQ-020 SHALL, in DONE, assert done=1, load product<=acc, deassert busy, and return to IDLE on the next edge.
REQ-021 SHALL drive gin=010, a=0, b=0 in IDLE and DONE; ALU outputs are a combinational decode of state and registers; alu_sum and alu_stat are consumed in the same cycle.
REQ-022 SHALL ignore start in every state other than IDLE; start high in the DONE cycle SHALL have no effect.
REQ-023 SHALL truncate silently on overflow; there is no overflow flag.
REQ-024 SHALL take 2 cycles per iteration for a multiplier bit of 0 and 3 cycles for a 1, plus one DONE cycle.

Reset
REQ-025 SHALL, on rst_n low at any time, including mid-operation, immediately enter IDLE and abandon the operation.
REQ-026 SHALL reset busy=0, done=0, product=0, acc=0, mcand=0, mplier=0, counter=0.
REQ-027 SHALL, after rst_n deasserts, accept start on the first rising edge.
REQ-028 SHALL NOT assert done for an operation aborted by reset.

Configuration
REQ-029 SHALL, with ALU_MUL_EARLY_EXIT_EN defined, terminate after any SHIFT whose updated mplier is zero, or when the counter reaches 31.
REQ-030 SHALL, without ALU_MUL_EARLY_EXIT_EN, always run exactly 32 iterations, terminating after the SHIFT in which the counter is 31, with identical product.

Verification
REQ-031 SHALL check: op_a=3, op_b=5, early exit -> gin sequence 000,010,100,000,100,000,010,100; done high in the cycle after edge E0+8; product=15.
REQ-032 SHALL check: op_a=7, op_b=0, early exit -> CHECK then SHIFT; done in the cycle after E0+2; product=0.
REQ-033 SHALL check: op_a=1, op_b=0xFFFFFFFF, without the macro -> 96 working cycles, then done; product=0xFFFFFFFF.
REQ-034 SHALL check: op_a=0x10000, op_b=0x10000 -> product=0 (truncation); op_a=0xFFFF, op_b=0xFFFF -> product=0xFFFE0001.
REQ-035 SHALL check: start pulsed while busy -> ignored; the original product completes unchanged, and busy never drops early.
REQ-036 SHALL check: rst_n low in the third cycle of an operation -> busy=0, done=0, product=0 immediately; a fresh 6*7 afterwards -> product=42.
